// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with a 2-entry {pc, instr} queue feeding decode.
module ifetch_unit #(
  parameter int          MEM_BYTES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        fault,
  output logic [31:0] retired_cnt
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] slot_pc    [2];
  logic [31:0] slot_instr [2];
  logic [1:0]  count;
  logic [1:0]  wr_idx;
  logic        pop;
  logic        push;
  logic        redirect_ok;
  logic        redirect_bad;

  assign imem_addr = pc;
  assign if_valid  = (count != 2'd0);
  assign if_pc     = slot_pc[0];
  assign if_instr  = slot_instr[0];
  assign fault     = (state == FAULT);

  assign pop          = if_valid && if_ready;
  assign redirect_ok  = redirect_valid && (state != FAULT) && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_valid && (state != FAULT) && (redirect_pc[1:0] != 2'b00);
  // Any redirect request, even a rejected one, suppresses the push for that cycle.
  assign push         = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
  // Slot index the new entry lands in once the same-cycle pop has shifted the queue.
  assign wr_idx       = count - {1'b0, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en) state_next = RUN;
      RUN:     if (!fetch_en) state_next = IDLE;
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
    if (redirect_bad) begin
      state_next = FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      count       <= 2'd0;
      retired_cnt <= 32'd0;
    end else begin
      if (pop) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if (redirect_ok) begin
        count <= 2'd0;
        pc    <= redirect_pc & ADDR_MASK;
      end else begin
        if (pop) begin
          slot_pc[0]    <= slot_pc[1];
          slot_instr[0] <= slot_instr[1];
        end
        // Placed after the shift so a push into slot 0 overrides it.
        if (push) begin
          slot_pc[wr_idx[0]]    <= pc;
          slot_instr[wr_idx[0]] <= imem_rdata;
          pc                    <= (pc + 32'd4) & ADDR_MASK;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized and directed bench for ifetch_unit against a queue-based model.
module tb_ifetch_unit;

  localparam int MB = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fault;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  ifetch_unit #(.MEM_BYTES(MB), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .fault(fault), .retired_cnt(retired_cnt)
  );

  logic [31:0] mem [0:7];
  assign imem_rdata = mem[imem_addr[4:2]];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_ret;
  bit          m_run;
  bit          m_fault;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Abstract model: a queue of fetched words, a PC, and run/fault flags.
  task automatic model_update();
    int  n;
    bit  do_pop;
    bit  do_push;
    if (reset) begin
      q.delete();
      m_pc    = 32'h0;
      m_ret   = 0;
      m_run   = 0;
      m_fault = 0;
    end else begin
      n       = q.size();
      do_pop  = (n > 0) && if_ready;
      do_push = m_run && !m_fault && !redirect_valid && (n < 2 || do_pop);
      if (do_pop) begin
        void'(q.pop_front());
        m_ret = m_ret + 1;
      end
      if (do_push) begin
        q.push_back('{pc: m_pc, instr: mem[m_pc / 4]});
        m_pc = (m_pc + 4) % MB;
      end
      if (redirect_valid && !m_fault) begin
        if (redirect_pc % 4 == 0) begin
          q.delete();
          m_pc = redirect_pc % MB;
        end else begin
          m_fault = 1;
        end
      end
      m_run = fetch_en;
    end
  endtask

  task automatic compare();
    chk("if_valid", 32'(if_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("if_pc", if_pc, q[0].pc);
      chk("if_instr", if_instr, q[0].instr);
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("retired_cnt", retired_cnt, m_ret);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic r, input logic fe, input logic rv, input logic [31:0] rp,
                       input logic rdy);
    reset          = r;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rp;
    if_ready       = rdy;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    step();
  endtask

  initial begin
    int          k;
    int          c;
    int          first;
    logic [31:0] exp3 [3];
    logic [31:0] rp;

    for (int i = 0; i < 8; i++) mem[i] = $urandom;
    q.delete();
    m_pc = 0; m_ret = 0; m_run = 0; m_fault = 0;

    @(negedge clk);
    do_reset();
    chk("rst_if_valid", 32'(if_valid), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_retired", retired_cnt, 32'h0);

    // Streaming with wrap back to address 0.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    chk("post_reset_addr", imem_addr, 32'h0);
    k = 0; c = 0; first = 0;
    while (k < 9 && c < 40) begin
      if (if_valid) begin
        if (k == 0) first = c;
        chk("stream_pc", if_pc, 32'((k * 4) % MB));
        chk("stream_instr", if_instr, mem[k % 8]);
        k++;
      end
      if (k < 9) begin
        step();
        c++;
      end
    end
    chk("stream_accepts", 32'(k), 32'd9);
    chk("stream_back_to_back", 32'(c - first), 32'd8);
    step();
    chk("stream_retired", retired_cnt, 32'd9);

    // Backpressure.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) step();
    chk("bp_addr_early", imem_addr, 32'h8);
    step();
    chk("bp_model_depth", 32'(q.size()), 32'd2);
    chk("bp_valid", 32'(if_valid), 32'h1);
    chk("bp_pc", if_pc, 32'h0);
    chk("bp_addr", imem_addr, 32'h8);
    exp3[0] = 32'h0; exp3[1] = 32'h4; exp3[2] = 32'h8;
    if_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_drain_valid", 32'(if_valid), 32'h1);
      chk("bp_drain_pc", if_pc, exp3[i]);
      step();
    end

    // Redirect over a full queue, then continue across the wrap.
    if_ready = 1'b0;
    repeat (3) step();
    drive(1'b0, 1'b1, 1'b1, 32'h14, 1'b0);
    step();
    chk("redir_n1_valid", 32'(if_valid), 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    chk("redir_n2_valid", 32'(if_valid), 32'h1);
    chk("redir_n2_pc", if_pc, 32'h14);
    step();
    chk("redir_next_pc", if_pc, 32'h18);

    // Wrap from the last word of memory.
    drive(1'b0, 1'b1, 1'b1, 32'h1C, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    step();
    chk("wrap_pc0", if_pc, 32'h1C);
    step();
    chk("wrap_pc1", if_pc, 32'h0);
    step();
    chk("wrap_pc2", if_pc, 32'h4);

    // Misaligned redirect.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    repeat (4) step();
    drive(1'b0, 1'b1, 1'b1, 32'h6, 1'b0);
    step();
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_addr", imem_addr, 32'h8);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("mis_drain0", if_pc, 32'h0);
    step();
    chk("mis_drain1", if_pc, 32'h4);
    step();
    chk("mis_empty", 32'(if_valid), 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) begin
      step();
      chk("mis_ignored_valid", 32'(if_valid), 32'h0);
      chk("mis_ignored_addr", imem_addr, 32'h8);
      chk("mis_sticky", 32'(fault), 32'h1);
    end

    // Reset with a full queue.
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    repeat (6) step();
    if_ready = 1'b0;
    repeat (3) step();
    chk("mid_model_depth", 32'(q.size()), 32'd2);
    reset = 1'b1;
    step();
    chk("mid_valid", 32'(if_valid), 32'h0);
    chk("mid_retired", retired_cnt, 32'h0);
    chk("mid_addr", imem_addr, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rp = $urandom;
      if ($urandom_range(99, 0) < 85) rp[1:0] = 2'b00;
      drive(1'b0, 1'($urandom_range(99, 0) < 80), 1'($urandom_range(99, 0) < 10), rp,
            1'($urandom_range(99, 0) < 60));
      if ($urandom_range(199, 0) == 0) reset = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 32, meaning the instruction memory size in bytes; it is a power of two and at least 8.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset; it is word-aligned.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port fetch_en, input, 1 bit: fetch permitted when high.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: byte address presented to the instruction memory.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: little-endian word returned combinationally by the instruction memory for imem_addr.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-009 The block SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-010 The block SHALL have port if_valid, output, 1 bit: instruction available to decode.
REQ-011 The block SHALL have port if_ready, input, 1 bit: decode accepts the instruction.
REQ-012 The block SHALL have port if_instr, output, 32 bits: instruction at the queue head.
REQ-013 The block SHALL have port if_pc, output, 32 bits: PC of if_instr.
REQ-014 The block SHALL have port fault, output, 1 bit: sticky misaligned-redirect fault.
REQ-015 The block SHALL have port retired_cnt, output, 32 bits: count of instructions accepted by decode.

Function
REQ-016 The block SHALL implement the states IDLE, RUN and FAULT.
- Transitions: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0; any state->FAULT on an accepted misaligned redirect.
- FAULT is left only by reset.
REQ-017 The block SHALL drive imem_addr from the PC register combinationally.
REQ-018 The block SHALL contain a 2-entry FIFO of {pc, instr}; if_valid=1 when the FIFO is non-empty; if_instr and if_pc come from the head entry.
REQ-019 A push SHALL occur in RUN state, with redirect_valid=0, when the FIFO holds fewer than 2 entries or a pop occurs in the same cycle.
- A push writes {pc, imem_rdata}.
- A push updates pc <= (pc+4) mod MEM_BYTES, so the PC wraps from MEM_BYTES-4 to 0.
REQ-020 A pop SHALL occur when if_valid=1 and if_ready=1.
- A pop increments retired_cnt by 1, with modulo 2^32 wrap.
- A simultaneous push and pop on a full FIFO leaves its occupancy at 2.
REQ-021 The PC SHALL advance only on a push; in IDLE state, on a full FIFO without a pop, or in FAULT state, the PC holds its value.
REQ-022 The block SHALL handle redirect_valid=1 with redirect_pc[1:0]=0, in state IDLE or RUN, as follows:
- Flush the FIFO to empty; a same-cycle pop still counts in retired_cnt.
- Perform no push that cycle.
- Set pc <= redirect_pc mod MEM_BYTES.
- The first target instruction appears on if_valid 2 cycles after the redirect cycle, provided the block is in RUN state.
REQ-023 The block SHALL handle redirect_valid=1 with redirect_pc[1:0]!=0, in state IDLE or RUN, as follows:
- Set fault to 1 and enter FAULT.
- Leave the PC unchanged and do not flush the FIFO.
REQ-024 In FAULT state, the block SHALL ignore redirects and perform no pushes; FIFO entries already present SHALL still drain through the handshake.
REQ-025 The block SHALL hold if_instr and if_pc stable while if_valid=1 and if_ready=0, unless a redirect flushes the FIFO.
REQ-026 In RUN state with if_ready held at 1, the block SHALL sustain a throughput of 1 instruction per cycle.

Reset
REQ-027 While reset=1, the block SHALL set the following, taking priority over all other inputs:
- pc=RESET_PC and state=IDLE.
- FIFO empty, so if_valid=0.
- fault=0 and retired_cnt=0.
REQ-028 A reset asserted mid-operation SHALL discard all FIFO entries and any pending redirect in the same cycle.
REQ-029 On the first cycle after reset is deasserted, imem_addr SHALL equal RESET_PC.

Verification
REQ-030 Streaming: with reset released, fetch_en=1 and if_ready=1, the bench SHALL check that if_pc = 0, 4, 8, ..., 28, 0 on consecutive cycles, that if_instr matches each memory word, and that retired_cnt=9 after 9 accepts.
REQ-031 Backpressure: with if_ready=0 for 5 cycles, the bench SHALL check that the FIFO holds 2 entries, that imem_addr stays at 8, that if_pc holds 0, and that after release if_pc = 0, 4, 8 follows in order.
REQ-032 Redirect: with redirect_valid=1 and redirect_pc=32'h14 at cycle N, the bench SHALL check that if_valid=0 at N+1, that at N+2 if_valid=1 with if_pc=32'h14, and that previously queued entries never appear.
REQ-033 Misaligned: with redirect_pc=32'h6, the bench SHALL check that fault=1 on the next cycle, that queued entries drain, that if_valid then stays 0, and that a later aligned redirect is ignored.
REQ-034 Wrap: with a redirect to 32'h1C (MEM_BYTES=32), the bench SHALL check that if_pc = 32'h1C, 32'h0, 32'h4 in sequence.
REQ-035 Reset mid-stream: with reset asserted while the FIFO holds 2 entries, the bench SHALL check that on the next cycle if_valid=0, retired_cnt=0 and imem_addr=RESET_PC.
